// File: rtl/hs32_div_issue_arb.sv
// hs32_div_issue_arb: round-robin two-requester arbiter and sequencer for the hs32 divider.
// Build option HS32_DIV_ZERO_BYPASS_EN answers zero-divisor requests without issuing them.
module hs32_div_issue_arb #(
  parameter int DIV_LAT = 40,
  parameter int TAG_W   = 5
) (
  input  logic               CCLK,
  input  logic               SSE_L,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [127:0]       req_dvd_hi,
  input  logic [127:0]       req_dvd_lo,
  input  logic [127:0]       req_dvsr,
  input  logic [1:0]         req_signed,
  input  logic [1:0]         req_dual,
  input  logic [1:0]         req_div8,
  input  logic [7:0]         req_resen,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               al_is_DivIssue1_8,
  output logic               al_is_Div8Divh1_8,
  output logic               al_is_SignedMulDiv1_8,
  output logic               al_is_DualResMulDiv1_8,
  output logic [3:0]         al_is_ResEnable1_8,
  output logic [63:0]        Dividend_hi,
  output logic [63:0]        Dividend_lo,
  output logic [63:0]        Divisor,
  input  logic [63:0]        DivResBus_8,
  input  logic               DivError_8,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [63:0]        rsp_quo,
  output logic [63:0]        rsp_rem,
  output logic               rsp_err,
  output logic               busy
);

  localparam int CNT_W = $clog2(DIV_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_HOLD  = 3'd2,
    S_WAIT  = 3'd3,
    S_CAP0  = 3'd4,
    S_CAP1  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t             r_state;
  logic               r_rr;
  logic               r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_issue;
  logic               r_div8;
  logic               r_signed;
  logic               r_dual;
  logic [3:0]         r_resen;
  logic [63:0]        r_dvd_hi;
  logic [63:0]        r_dvd_lo;
  logic [63:0]        r_dvsr;
  logic [1:0]         r_rsp_valid;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [63:0]        r_rsp_quo;
  logic [63:0]        r_rsp_rem;
  logic               r_rsp_err;

  logic [63:0]        w_dvd_hi [2];
  logic [63:0]        w_dvd_lo [2];
  logic [63:0]        w_dvsr   [2];
  logic [3:0]         w_resen  [2];
  logic [TAG_W-1:0]   w_tag    [2];
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_sel;
  logic [1:0]         w_win_oh;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_req
    assign w_dvd_hi[gi] = req_dvd_hi[gi*64 +: 64];
    assign w_dvd_lo[gi] = req_dvd_lo[gi*64 +: 64];
    assign w_dvsr[gi]   = req_dvsr[gi*64 +: 64];
    assign w_resen[gi]  = req_resen[gi*4 +: 4];
    assign w_tag[gi]    = req_tag[gi*TAG_W +: TAG_W];
  end

  // r_rr holds the last winner; on contention the other requester goes first.
  always_comb begin
    w_grant = 2'b00;
    if (SSE_L && (r_state == S_IDLE)) begin
      if (req_valid == 2'b11) begin
        w_grant = r_rr ? 2'b01 : 2'b10;
      end else begin
        w_grant = req_valid;
      end
    end
  end

  assign w_accept = |w_grant;
  assign w_sel    = w_grant[1];
  assign w_win_oh = r_win ? 2'b10 : 2'b01;

`ifdef HS32_DIV_ZERO_BYPASS_EN
  logic w_zero_dvsr;
  assign w_zero_dvsr = (w_dvsr[w_sel] == 64'd0);
`endif

  always_ff @(posedge CCLK) begin
    if (!SSE_L) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_win       <= 1'b0;
      r_cnt       <= '0;
      r_issue     <= 1'b0;
      r_div8      <= 1'b0;
      r_signed    <= 1'b0;
      r_dual      <= 1'b0;
      r_resen     <= 4'd0;
      r_dvd_hi    <= 64'd0;
      r_dvd_lo    <= 64'd0;
      r_dvsr      <= 64'd0;
      r_rsp_valid <= 2'b00;
      r_rsp_tag   <= '0;
      r_rsp_quo   <= 64'd0;
      r_rsp_rem   <= 64'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rr      <= w_sel;
            r_win     <= w_sel;
            r_rsp_tag <= w_tag[w_sel];
`ifdef HS32_DIV_ZERO_BYPASS_EN
            if (w_zero_dvsr) begin
              r_rsp_quo   <= 64'd0;
              r_rsp_rem   <= 64'd0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= w_grant;
              r_state     <= S_RESP;
            end else
`endif
            begin
              r_dvd_hi <= w_dvd_hi[w_sel];
              r_dvd_lo <= w_dvd_lo[w_sel];
              r_dvsr   <= w_dvsr[w_sel];
              r_resen  <= w_resen[w_sel];
              r_signed <= req_signed[w_sel];
              r_dual   <= req_dual[w_sel];
              r_div8   <= req_div8[w_sel];
              r_issue  <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_issue <= 1'b0;
          r_cnt   <= CNT_W'(1);
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(2)) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter equals cycles since issue, so CAP0 lands DIV_LAT cycles after it.
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIV_LAT - 1)) begin
            r_state <= S_CAP0;
          end
        end
        S_CAP0: begin
          r_cnt     <= '0;
          r_rsp_quo <= DivResBus_8;
          r_rsp_err <= DivError_8;
          if (r_dual && !DivError_8) begin
            r_state <= S_CAP1;
          end else begin
            r_rsp_rem   <= 64'd0;
            r_rsp_valid <= w_win_oh;
            r_state     <= S_RESP;
          end
        end
        S_CAP1: begin
          r_rsp_rem   <= DivResBus_8;
          r_rsp_valid <= w_win_oh;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[r_win]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready              = w_grant;
  assign al_is_DivIssue1_8      = r_issue;
  assign al_is_Div8Divh1_8      = r_div8;
  assign al_is_SignedMulDiv1_8  = r_signed;
  assign al_is_DualResMulDiv1_8 = r_dual;
  assign al_is_ResEnable1_8     = r_resen;
  assign Dividend_hi            = r_dvd_hi;
  assign Dividend_lo            = r_dvd_lo;
  assign Divisor                = r_dvsr;
  assign rsp_valid              = r_rsp_valid;
  assign rsp_tag                = r_rsp_tag;
  assign rsp_quo                = r_rsp_quo;
  assign rsp_rem                = r_rsp_rem;
  assign rsp_err                = r_rsp_err;
  assign busy                   = (r_state != S_IDLE);

endmodule

// File: tb/tb_hs32_div_issue_arb.sv
// Bench for hs32_div_issue_arb: behavioural divider model plus a cycle-level reference of
// arbitration, response timing and response contents.
`timescale 1ns/1ps
module tb_hs32_div_issue_arb;
  localparam int DIV_LAT = 40;
  localparam int TAG_W   = 5;
  localparam logic [63:0] ERR_QUO = 64'hDEAD_0BAD_DEAD_0BAD;

  logic               CCLK = 1'b0;
  logic               SSE_L;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [127:0]       req_dvd_hi, req_dvd_lo, req_dvsr;
  logic [1:0]         req_signed, req_dual, req_div8;
  logic [7:0]         req_resen;
  logic [2*TAG_W-1:0] req_tag;
  logic               al_is_DivIssue1_8, al_is_Div8Divh1_8, al_is_SignedMulDiv1_8, al_is_DualResMulDiv1_8;
  logic [3:0]         al_is_ResEnable1_8;
  logic [63:0]        Dividend_hi, Dividend_lo, Divisor;
  logic [63:0]        DivResBus_8 = 64'd0;
  logic               DivError_8 = 1'b0;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [TAG_W-1:0]   rsp_tag;
  logic [63:0]        rsp_quo, rsp_rem;
  logic               rsp_err, busy;

  always #5 CCLK = ~CCLK;

  hs32_div_issue_arb #(.DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .CCLK(CCLK), .SSE_L(SSE_L),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dvd_hi(req_dvd_hi), .req_dvd_lo(req_dvd_lo), .req_dvsr(req_dvsr),
    .req_signed(req_signed), .req_dual(req_dual), .req_div8(req_div8),
    .req_resen(req_resen), .req_tag(req_tag),
    .al_is_DivIssue1_8(al_is_DivIssue1_8), .al_is_Div8Divh1_8(al_is_Div8Divh1_8),
    .al_is_SignedMulDiv1_8(al_is_SignedMulDiv1_8), .al_is_DualResMulDiv1_8(al_is_DualResMulDiv1_8),
    .al_is_ResEnable1_8(al_is_ResEnable1_8),
    .Dividend_hi(Dividend_hi), .Dividend_lo(Dividend_lo), .Divisor(Divisor),
    .DivResBus_8(DivResBus_8), .DivError_8(DivError_8),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct packed {
    logic [63:0]      hi;
    logic [63:0]      lo;
    logic [63:0]      dvsr;
    logic             sgn;
    logic             dual;
    logic             div8;
    logic [3:0]       resen;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        e;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic req_t mk(input logic [63:0] hi, lo, dv, input logic sgn, dual, div8,
                              input logic [3:0] resen, input logic [TAG_W-1:0] tag);
    req_t q;
    q.hi = hi; q.lo = lo; q.dvsr = dv; q.sgn = sgn; q.dual = dual; q.div8 = div8;
    q.resen = resen; q.tag = tag;
    return q;
  endfunction

  // What an ideal divider returns: quotient/remainder of the 128b dividend, error on /0.
  function automatic res_t ref_div(input logic [63:0] hi, lo, dv, input logic sgn);
    res_t o;
    logic [127:0] n, d, qq, rr;
    n = {hi, lo};
    d = {{64{sgn & dv[63]}}, dv};
    if (dv == 64'd0) begin
      o.q = ERR_QUO; o.r = 64'd0; o.e = 1'b1;
    end else begin
      if (sgn) begin
        qq = 128'($signed(n) / $signed(d));
        rr = 128'($signed(n) % $signed(d));
      end else begin
        qq = n / d;
        rr = n % d;
      end
      o.q = qq[63:0]; o.r = rr[63:0]; o.e = 1'b0;
    end
    return o;
  endfunction

  function automatic res_t exp_res(input req_t q);
    res_t o;
    o = ref_div(q.hi, q.lo, q.dvsr, q.sgn);
    if (!q.dual || o.e) o.r = 64'd0;
`ifdef HS32_DIV_ZERO_BYPASS_EN
    if (q.dvsr == 64'd0) begin o.q = 64'd0; o.r = 64'd0; o.e = 1'b1; end
`endif
    return o;
  endfunction

  // Cycles from the accept cycle to the first cycle of the response.
  function automatic int exp_lat(input req_t q);
`ifdef HS32_DIV_ZERO_BYPASS_EN
    if (q.dvsr == 64'd0) return 1;
`endif
    return 1 + DIV_LAT + 1 + ((q.dual && q.dvsr != 64'd0) ? 1 : 0);
  endfunction

  // Divider model: result beats DIV_LAT and DIV_LAT+1 cycles after the issue cycle.
  int   mcyc = 0;
  int   m_issue = -1000;
  res_t m_res = '0;
  always @(negedge CCLK) begin
    mcyc <= mcyc + 1;
    if (al_is_DivIssue1_8) begin
      m_issue <= mcyc;
      m_res   <= ref_div(Dividend_hi, Dividend_lo, Divisor, al_is_SignedMulDiv1_8);
    end
    if (mcyc == m_issue + DIV_LAT) begin
      DivResBus_8 <= m_res.q;
      DivError_8  <= m_res.e;
    end else if (mcyc == m_issue + DIV_LAT + 1) begin
      DivResBus_8 <= m_res.r;
      DivError_8  <= 1'($urandom);
    end else begin
      DivResBus_8 <= {$urandom, $urandom};
      DivError_8  <= 1'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int r, input req_t q);
    req_dvd_hi[r*64 +: 64]   = q.hi;
    req_dvd_lo[r*64 +: 64]   = q.lo;
    req_dvsr[r*64 +: 64]     = q.dvsr;
    req_signed[r]            = q.sgn;
    req_dual[r]              = q.dual;
    req_div8[r]              = q.div8;
    req_resen[r*4 +: 4]      = q.resen;
    req_tag[r*TAG_W +: TAG_W] = q.tag;
  endtask

  // Reference state
  req_t pq0[$], pq1[$];
  int   glog[$];
  int   ecyc = 0;
  bit   busy_m = 1'b0;
  int   last_w = 0;
  int   win_m = 0;
  int   acc_m = 0;
  int   lat_m = 0;
  req_t op_m;
  res_t ex_m;
  res_t last_seen;
  logic [TAG_W-1:0] last_tag;

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_issue"}, al_is_DivIssue1_8, 0);
    chk({tag, "_ctl"}, {al_is_Div8Divh1_8, al_is_SignedMulDiv1_8, al_is_DualResMulDiv1_8, al_is_ResEnable1_8}, 0);
    chk({tag, "_dvd_hi"}, Dividend_hi, 0);
    chk({tag, "_dvd_lo"}, Dividend_lo, 0);
    chk({tag, "_dvsr"}, Divisor, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_tag"}, rsp_tag, 0);
    chk({tag, "_rsp_quo"}, rsp_quo, 0);
    chk({tag, "_rsp_rem"}, rsp_rem, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset(input int n, input string tag);
    @(negedge CCLK);
    SSE_L = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
    repeat (n) @(negedge CCLK);
    #1;
    chk_zero(tag);
    SSE_L = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    busy_m = 1'b0; last_w = 0;
  endtask

  // Runs queued requests to completion, checking every cycle against the reference.
  task automatic run(input int max_cyc, input int hold, input string tag);
    int t;
    bit done;
    logic [1:0] exp_rdy, oh;
    done = 1'b0;
    for (int k = 0; k < max_cyc && !done; k++) begin
      @(negedge CCLK);
      ecyc++;
      if (pq0.size() > 0) drive_req(0, pq0[0]);
      if (pq1.size() > 0) drive_req(1, pq1[0]);
      req_valid = {pq1.size() > 0, pq0.size() > 0};
      #1;
      chk({tag, "_busy"}, busy, busy_m);
      exp_rdy = 2'b00;
      if (!busy_m && req_valid != 2'b00)
        exp_rdy = (req_valid == 2'b11) ? ((last_w != 0) ? 2'b01 : 2'b10) : req_valid;
      chk({tag, "_req_ready"}, req_ready, exp_rdy);
      rsp_ready = 2'($urandom);
      if (busy_m) begin
        t  = ecyc - acc_m;
        oh = (win_m != 0) ? 2'b10 : 2'b01;
        chk({tag, "_issue"}, al_is_DivIssue1_8, (t == 1 && lat_m != 1) ? 1 : 0);
        if (t >= 1 && t <= 3 && lat_m != 1) begin
          chk({tag, "_dvd_hi"}, Dividend_hi, op_m.hi);
          chk({tag, "_dvd_lo"}, Dividend_lo, op_m.lo);
          chk({tag, "_dvsr"}, Divisor, op_m.dvsr);
          chk({tag, "_ctl"}, {al_is_Div8Divh1_8, al_is_SignedMulDiv1_8, al_is_DualResMulDiv1_8, al_is_ResEnable1_8},
              {op_m.div8, op_m.sgn, op_m.dual, op_m.resen});
        end
        chk({tag, "_rsp_valid"}, rsp_valid, (t >= lat_m) ? oh : 2'b00);
        if (t >= lat_m) begin
          chk({tag, "_rsp_tag"}, rsp_tag, op_m.tag);
          chk({tag, "_rsp_quo"}, rsp_quo, ex_m.q);
          chk({tag, "_rsp_rem"}, rsp_rem, ex_m.r);
          chk({tag, "_rsp_err"}, rsp_err, ex_m.e);
          if (t == lat_m) begin
            last_seen = {rsp_quo, rsp_rem, rsp_err};
            last_tag  = rsp_tag;
          end
          rsp_ready[win_m] = (t >= lat_m + hold);
          if (t >= lat_m + hold) begin
            busy_m = 1'b0;
            $display("op r%0d tag=%0d quo=%h rem=%h err=%b accept->rsp=%0d", win_m, rsp_tag, rsp_quo, rsp_rem, rsp_err, lat_m);
          end
        end
      end else begin
        chk({tag, "_issue_idle"}, al_is_DivIssue1_8, 0);
        chk({tag, "_rsp_valid_idle"}, rsp_valid, 0);
      end
      if (exp_rdy != 2'b00) begin
        win_m = exp_rdy[1] ? 1 : 0;
        op_m  = (win_m != 0) ? pq1.pop_front() : pq0.pop_front();
        acc_m = ecyc; busy_m = 1'b1; last_w = win_m;
        ex_m  = exp_res(op_m); lat_m = exp_lat(op_m);
        glog.push_back(win_m);
      end
      if (!busy_m && pq0.size() == 0 && pq1.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: observed not-done expected done within %0d cycles", tag, max_cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    req_t rq;
    SSE_L = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_dvd_hi = '0; req_dvd_lo = '0; req_dvsr = '0; req_signed = '0; req_dual = '0;
    req_div8 = '0; req_resen = '0; req_tag = '0;
    apply_reset(3, "reset");

    // r0 alone, unsigned dual 100/7
    pq0.push_back(mk(64'd0, 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 4'hF, 5'd3));
    run(200, 0, "A");
    chk("A_quo", last_seen.q, 64'd14);
    chk("A_rem", last_seen.r, 64'd2);
    chk("A_err", last_seen.e, 0);
    chk("A_tag", last_tag, 3);

    // contention right after reset, with a third r1 request queued behind
    apply_reset(2, "reset2");
    glog.delete();
    pq0.push_back(mk(64'd0, 64'd5555, 64'd11, 1'b0, 1'b0, 1'b0, 4'h3, 5'd10));
    pq1.push_back(mk(64'd1, 64'd77, 64'd13, 1'b0, 1'b1, 1'b0, 4'h5, 5'd21));
    pq1.push_back(mk(64'd0, 64'd999, 64'd4, 1'b1, 1'b1, 1'b1, 4'hA, 5'd22));
    run(400, 0, "B");
    chk("B_ngrants", glog.size(), 3);
    chk("B_grant0", glog[0], 1);
    chk("B_grant1", glog[1], 0);
    chk("B_grant2", glog[2], 1);

    // non-dual 8-bit 200/9 with response back-pressure; r1 waits throughout
    pq0.push_back(mk(64'd0, 64'd200, 64'd9, 1'b0, 1'b0, 1'b1, 4'h1, 5'd5));
    pq1.push_back(mk(64'd0, 64'd300, 64'd7, 1'b0, 1'b1, 1'b0, 4'h2, 5'd6));
    run(400, 10, "C");
    chk("C_order0", glog[3], 0);
    chk("C_order1", glog[4], 1);

    // divide by zero, signed dual
    pq0.push_back(mk(64'd0, 64'd1234, 64'd0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd9));
    run(200, 1, "D");
    chk("D_err", last_seen.e, 1);
    chk("D_rem", last_seen.r, 64'd0);

    // randomized batches
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 3; j++) begin
        rq = mk({32'd0, ($urandom_range(0, 1) != 0) ? $urandom : 32'd0}, {$urandom, $urandom},
                64'd0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 5'($urandom));
        case ($urandom_range(0, 4))
          0:       rq.dvsr = 64'd0;
          1:       rq.dvsr = 64'($urandom_range(1, 255));
          default: rq.dvsr = {$urandom, $urandom};
        endcase
        if ($urandom_range(0, 1) != 0) pq1.push_back(rq); else pq0.push_back(rq);
      end
      run(600, $urandom_range(0, 3), "RND");
    end

    // reset in the middle of WAIT; late divider beat must be ignored
    @(negedge CCLK);
    drive_req(0, mk(64'd0, 64'd5000, 64'd3, 1'b0, 1'b1, 1'b0, 4'hF, 5'd7));
    req_valid = 2'b01; #1;
    chk("E_accept", req_ready, 2'b01);
    @(negedge CCLK);
    req_valid = 2'b00;
    chk("E_issue", al_is_DivIssue1_8, 1);
    repeat (7) @(negedge CCLK);
    chk("E_busy_wait", busy, 1);
    apply_reset(1, "E_rst");
    for (int k = 0; k < DIV_LAT + 4; k++) begin
      @(negedge CCLK);
      chk("E_idle_busy", busy, 0);
      chk("E_idle_rsp_valid", rsp_valid, 0);
    end
    pq0.push_back(mk(64'd0, 64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, 4'h1, 5'd12));
    run(200, 0, "E");
    chk("E_quo", last_seen.q, 64'd100);
    chk("E_tag", last_tag, 12);

    repeat (3) @(negedge CCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs32_div_issue_arb.md
Name: hs32_div_issue_arb

Overview:
- Two-requester arbiter and sequencer in front of the hs32 divider top.
- Accepts divide requests over valid/ready, picks one round-robin, and latches its operands.
- Drives the divider's issue/control inputs for the fixed operand window, counts the divider latency, and captures result beat(s) and error.
- Returns a tagged response to the winning requester. One divide in flight at a time.

Parameters:
- DIV_LAT, 40, cycles from issue cycle to first result beat on DivResBus_8 (min 4).
- TAG_W, 5, request/response tag width.

Ports:
- CCLK  in  1  clock.
- SSE_L  in  1  synchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_dvd_hi  in  128  {r1,r0} dividend high 64b.
- req_dvd_lo  in  128  {r1,r0} dividend low 64b.
- req_dvsr  in  128  {r1,r0} divisor.
- req_signed  in  2  signed divide.
- req_dual  in  2  dual-result divide (quotient+remainder).
- req_div8  in  2  div8/divh class op.
- req_resen  in  8  {r1,r0} 4b result enables.
- req_tag  in  2*TAG_W  {r1,r0} tag.
- al_is_DivIssue1_8  out  1  divider issue strobe.
- al_is_Div8Divh1_8, al_is_SignedMulDiv1_8, al_is_DualResMulDiv1_8  out  1 each  latched control.
- al_is_ResEnable1_8  out  4  latched enables.
- Dividend_hi, Dividend_lo, Divisor  out  64 each  latched operands.
- DivResBus_8  in  64  divider result.
- DivError_8  in  1  divider error.
- rsp_valid  out  2  one-hot response valid.
- rsp_ready  in  2  response accept.
- rsp_tag  out  TAG_W  response tag.
- rsp_quo  out  64  quotient.
- rsp_rem  out  64  remainder; 0 if not dual.
- rsp_err  out  1  divide error.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Reset (SSE_L=0 at CCLK edge): state IDLE, rr pointer=0, counter=0. All outputs 0, including operand/control regs and response regs. Reset overrides every state, including mid-WAIT; any divider result arriving after reset is ignored.
- States: IDLE, ISSUE, HOLD, WAIT, CAP0, CAP1, RESP.
- IDLE:
  - req_ready is combinational from req_valid and the rr pointer; it is asserted only in IDLE.
  - Both valid: grant the requester != rr pointer's last winner. Pointer flips to the winner on accept.
  - Accept cycle latches that requester's operands, controls and tag; next state ISSUE.
- ISSUE (1 cycle): al_is_DivIssue1_8=1, counter=1; next HOLD.
- HOLD: operands/controls held stable; counter increments; 2 cycles, then WAIT.
- WAIT: counter increments; when counter==DIV_LAT-1, next CAP0.
- CAP0: rsp_quo<=DivResBus_8, rsp_err<=DivError_8.
  - If dual & ~DivError_8: next CAP1.
  - Else: rsp_rem<=0, next RESP.
- CAP1: rsp_rem<=DivResBus_8; next RESP.
- RESP:
  - rsp_valid[winner]=1; rsp_tag/quo/rem/err held stable.
  - Leave to IDLE on the cycle rsp_ready[winner]=1. No new accept in that same cycle; earliest re-accept is the next cycle.
  - rsp_ready on the non-winner is ignored.
- Operand/control output regs keep their last values outside ISSUE/HOLD; al_is_DivIssue1_8 is 0 outside ISSUE.
- Issue-to-response latency: DIV_LAT+1 cycles (non-dual), DIV_LAT+2 (dual).
- Throughput: one op per DIV_LAT+3 cycles minimum.

Optional Feature:
- HS32_DIV_ZERO_BYPASS_EN.
- Defined: at accept, if the selected divisor==0, next state is RESP directly. Response is rsp_quo=0, rsp_rem=0, rsp_err=1, available the cycle after accept. al_is_DivIssue1_8 never pulses; divider untouched.
- Undefined: zero divisors go through the divider like any op, and the error comes from DivError_8.

Test Plan:
- r0 only, unsigned dual, 100/7, tag 3: one DivIssue pulse; rsp_valid=01 at DIV_LAT+2 cycles; quo=14, rem=2, err=0, tag=3.
- Both valid in IDLE after reset: r1 granted first (pointer=0). Then r0. Responses in that order; a third back-to-back r1 request waits for r0's grant.
- Non-dual 8-bit 200/9 with rsp_ready low for 10 cycles: rsp held stable (quo=22, rem=0); req_ready stays 0 throughout; re-accept the cycle after rsp_ready.
- Divisor 0, signed dual, macro undefined: model asserts DivError_8 in CAP0; CAP1 skipped; rsp_err=1, rem=0.
- Same with macro defined: no DivIssue pulse; rsp_valid the cycle after accept with quo=0, rem=0, err=1.
- SSE_L low 5 cycles into WAIT: all outputs 0 next edge; late divider result ignored; a new request afterwards completes correctly (1000/10 → quo=100).
